axis_byte_packer: RTL and testbench
===================================

Name: axis_byte_packer

Overview:
- Upstream feeder for the word-wide AXI-Stream memory controller.
- Accepts a byte-wide AXI-Stream, packs bytes little-endian into DATA_WIDTH words, and generates tstrb for partial words.
- Generates tlast at packet end, or forces it after MAX_PKT_WORDS words.
- Single registered output stage with full AXI-Stream backpressure.

Parameters:
- DATA_WIDTH, 32: output word width; must be a multiple of IN_WIDTH.
- IN_WIDTH, 8: input byte width.
- MAX_PKT_WORDS, 256: maximum words per output packet before tlast is forced; at least 1.
- CNT_WIDTH, 16: width of the packet counter.

Ports:
- s00_axis_aclk  in  1  single clock for both interfaces.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tdata  in  IN_WIDTH  input byte.
- s00_axis_tvalid  in  1  input byte valid.
- s00_axis_tlast  in  1  last byte of the input packet.
- s00_axis_tready  out  1  byte accepted when high with tvalid.
- m00_axis_tdata  out  DATA_WIDTH  packed word.
- m00_axis_tstrb  out  DATA_WIDTH/8  lane-valid mask.
- m00_axis_tvalid  out  1  word valid.
- m00_axis_tlast  out  1  last word of the packet.
- m00_axis_tready  in  1  downstream ready.
- pkt_count  out  CNT_WIDTH  count of emitted tlast words; wraps.
- forced_last  out  1  one-cycle pulse when tlast was forced by MAX_PKT_WORDS.

Behaviour:
- Clocking: one clock, s00_axis_aclk. Reset s00_axis_aresetn is asynchronous and active-low.
- Reset values: all outputs 0 (tdata, tstrb, tvalid, tlast, tready, pkt_count, forced_last). Lane index 0, accumulator and word counter 0, state IDLE.
- s00_axis_tready is registered and driven as the equivalent of (!m00_axis_tvalid || m00_axis_tready), gated by reset. The first cycle after reset release has tready=1.
- Byte acceptance: a byte is accepted on an edge where tvalid && tready.
  - The byte is written to lane L, bits [IN_WIDTH*L+IN_WIDTH-1 : IN_WIDTH*L], and strobe bit L is set.
  - Then L increments.
- Word completion: a word completes when L = LANES-1 (LANES = DATA_WIDTH/IN_WIDTH) or the accepted byte has tlast.
  - The word is loaded into the output register on the same edge.
  - m00_axis_tvalid rises the next cycle, so latency is 1 cycle from the final accepting edge.
  - Unfilled lanes carry tdata = 0 and tstrb = 0. Strobe bits are always contiguous from lane 0.
  - The accumulator clears and L returns to 0.
- Output tlast is set when the input tlast was present or the word counter equals MAX_PKT_WORDS-1. In the forced case, forced_last pulses for 1 cycle together with the load.
- Word counter: increments per loaded word and clears on every loaded tlast word.
- pkt_count increments on the handshake (tvalid && tready) of every tlast word; wraps at 2^CNT_WIDTH.
- Output hold rule: while m00_axis_tvalid && !m00_axis_tready, tdata, tstrb and tlast hold stable. m00_axis_tvalid may only drop after a handshake.
- Simultaneous drain and load: a drain and a new word load on the same edge are allowed, giving back-to-back words with no bubble. tvalid stays 1.
- States:
  - IDLE: no bytes of the current packet accepted yet. Moves to COLLECT on the first accepted byte without tlast.
  - COLLECT: returns to IDLE when a tlast word (input or forced) is loaded.
  - A single-byte packet with tlast goes IDLE -> IDLE.
- Input idle gaps (tvalid=0) leave all state unchanged; there is no timeout flush.
- Reset mid-operation: any partial word and the pending output word are discarded, and counters clear. The next byte after reset starts at lane 0 of a new packet.

Decomposition:
- Shared package axis_pkg: state encoding localparams (IDLE=1'b0, COLLECT=1'b1), LANES = DATA_WIDTH/IN_WIDTH, and the lane-index width function.
- One sub-module, axis_hold_reg: a one-deep output register with the tvalid/tready hold rule and a ready_for_load output. The packer core instantiates it.

Test Plan:
- Packet of 8 bytes 0x11..0x88, tlast on 0x88, m_tready=1.
  -> Word 0x44332211, strb 0xF, tlast 0; then word 0x88776655, strb 0xF, tlast 1; pkt_count = 1.
- Packet of 6 bytes 0x01..0x06, tlast on 0x06.
  -> Word 0x04030201, strb 0xF, tlast 0; then word 0x00000605, strb 0x3, tlast 1.
- Single byte 0xAB with tlast.
  -> Word 0x000000AB, strb 0x1, tlast 1, one cycle after acceptance; state remains IDLE.
- Backpressure: hold m_tready=0 for 5 cycles while the first word is valid.
  -> Output stable; s_tready=0; no bytes lost or duplicated; streaming resumes at 1 byte/cycle after release.
- MAX_PKT_WORDS=4: stream 20 bytes 0x00..0x13 with no tlast.
  -> 4th word 0x0F0E0D0C has tlast=1 with a forced_last pulse; 5th word 0x13121110 starts the next packet, tlast 0; pkt_count = 1.
- Assert reset after 2 bytes of a packet, then send bytes 0xA0..0xA3 with tlast.
  -> All outputs 0 during reset; next word is 0xA3A2A1A0, strb 0xF, tlast 1; pkt_count = 1.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and sizing helpers for the byte-to-word AXI-Stream packer.
package axis_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Number of input lanes that make up one output word.
  function automatic int unsigned lanes(input int unsigned data_width,
                                        input int unsigned in_width);
    return data_width / in_width;
  endfunction

  // Width of a lane index; a single-lane word still needs one bit.
  function automatic int unsigned lane_idx_width(input int unsigned n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// Byte-in / word-out stream bundle for axis_byte_packer.
interface axis_byte_packer_if #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [IN_WIDTH-1:0]   s00_axis_tdata;
  logic                  s00_axis_tvalid;
  logic                  s00_axis_tlast;
  logic                  s00_axis_tready;

  logic [DATA_WIDTH-1:0] m00_axis_tdata;
  logic [STRB_WIDTH-1:0] m00_axis_tstrb;
  logic                  m00_axis_tvalid;
  logic                  m00_axis_tlast;
  logic                  m00_axis_tready;

  // Packer side: sinks the byte stream, sources the word stream.
  modport slave (
    input  s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast,
    output s00_axis_tready,
    output m00_axis_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
    input  m00_axis_tready
  );

  // Environment side: sources bytes, sinks words.
  modport master (
    output s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast,
    input  s00_axis_tready,
    input  m00_axis_tdata, m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast,
    output m00_axis_tready
  );

endinterface

// File: rtl/axis_hold_reg.sv
// One-deep output register: loaded payload is held until the consumer accepts it.
module axis_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             ready_for_load
);

  // A new load is safe when the slot is empty or is draining on this edge.
  assign ready_for_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_byte_packer.sv
// Packs a byte-wide AXI-Stream little-endian into words with tstrb, tlast
// generation and a per-packet word cap.
module axis_byte_packer
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IN_WIDTH      = 8,
  parameter int unsigned MAX_PKT_WORDS = 256,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  axis_byte_packer_if.slave    axis,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 forced_last
);

  localparam int unsigned LANES  = lanes(DATA_WIDTH, IN_WIDTH);
  localparam int unsigned LIDX_W = lane_idx_width(LANES);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned BPL    = IN_WIDTH / 8;
  localparam int unsigned WCNT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam int unsigned HOLD_W = 1 + STRB_W + DATA_WIDTH;

  state_e                state_q, state_d;
  logic [LIDX_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d, word_data;
  logic [STRB_W-1:0]     acc_strb_q, acc_strb_d, word_strb;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  ready_en_q;
  logic                  ready_for_load;
  logic                  s_fire, m_fire;
  logic                  word_done, cap_hit, word_last, load, forced_d;
  logic [HOLD_W-1:0]     load_word, hold_data;

  assign axis.s00_axis_tready = ready_en_q & ready_for_load;
  assign s_fire = axis.s00_axis_tvalid & axis.s00_axis_tready;
  assign m_fire = axis.m00_axis_tvalid & axis.m00_axis_tready;

  // Lane merge, word completion, tlast/cap decision and packet FSM.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    acc_data_d = acc_data_q;
    acc_strb_d = acc_strb_q;
    wcnt_d     = wcnt_q;
    word_data  = acc_data_q;
    word_strb  = acc_strb_q;
    word_done  = 1'b0;
    word_last  = 1'b0;
    load       = 1'b0;
    forced_d   = 1'b0;
    cap_hit    = (wcnt_q == WCNT_W'(MAX_PKT_WORDS - 1));

    if (s_fire) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_q == LIDX_W'(i)) begin
          word_data[i*IN_WIDTH +: IN_WIDTH] = axis.s00_axis_tdata;
          word_strb[i*BPL +: BPL]           = '1;
        end
      end
      word_done = (lane_q == LIDX_W'(LANES - 1)) || axis.s00_axis_tlast;

      if (word_done) begin
        load       = 1'b1;
        word_last  = axis.s00_axis_tlast || cap_hit;
        forced_d   = !axis.s00_axis_tlast && cap_hit;
        acc_data_d = '0;
        acc_strb_d = '0;
        lane_d     = '0;
        wcnt_d     = word_last ? '0 : wcnt_q + WCNT_W'(1);
      end else begin
        acc_data_d = word_data;
        acc_strb_d = word_strb;
        lane_d     = lane_q + LIDX_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (s_fire) state_d = (load && word_last) ? IDLE : COLLECT;
      end
      COLLECT: begin
        if (load && word_last) state_d = IDLE;
      end
    endcase
  end

  assign load_word = {word_last, word_strb, word_data};

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      wcnt_q      <= '0;
      ready_en_q  <= 1'b0;
      forced_last <= 1'b0;
      pkt_count   <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      wcnt_q      <= wcnt_d;
      ready_en_q  <= 1'b1;
      forced_last <= forced_d;
      if (m_fire && axis.m00_axis_tlast) pkt_count <= pkt_count + CNT_WIDTH'(1);
    end
  end

  axis_hold_reg #(
    .WIDTH (HOLD_W)
  ) u_hold (
    .clk            (s00_axis_aclk),
    .rst_n          (s00_axis_aresetn),
    .load           (load),
    .load_data      (load_word),
    .out_ready      (axis.m00_axis_tready),
    .out_valid      (axis.m00_axis_tvalid),
    .out_data       (hold_data),
    .ready_for_load (ready_for_load)
  );

  assign axis.m00_axis_tlast = hold_data[HOLD_W-1];
  assign axis.m00_axis_tstrb = hold_data[DATA_WIDTH +: STRB_W];
  assign axis.m00_axis_tdata = hold_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer with a 4-word packet cap.
module tb_axis_byte_packer;

  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 8;
  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = 16;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] pkt_count;
  logic          forced_last;

  axis_byte_packer_if #(.IN_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  axis_byte_packer #(
    .DATA_WIDTH    (DW),
    .IN_WIDTH      (IW),
    .MAX_PKT_WORDS (MAXW),
    .CNT_WIDTH     (CW)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .axis             (bus),
    .pkt_count        (pkt_count),
    .forced_last      (forced_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic        f;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] s,
                             input logic l, input logic f);
    exp_t e;
    e.d = d; e.s = s; e.l = l; e.f = f;
    sb.push_back(e);
  endtask

  // Monitor: compare every output handshake against the scoreboard, and
  // check that a stalled word stays put.
  initial begin : monitor
    exp_t        e;
    logic        stall_q;
    logic [36:0] held;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", 64'(bus.m00_axis_tvalid), 64'(1));
          check("hold_word", 64'({bus.m00_axis_tlast, bus.m00_axis_tstrb, bus.m00_axis_tdata}),
                64'(held));
        end
        if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.m00_axis_tdata);
          end else begin
            e = sb.pop_front();
            check("word_data", 64'(bus.m00_axis_tdata), 64'(e.d));
            check("word_strb", 64'(bus.m00_axis_tstrb), 64'(e.s));
            check("word_last", 64'(bus.m00_axis_tlast), 64'(e.l));
            check("forced_last", 64'(forced_last), 64'(e.f));
          end
        end
        stall_q = bus.m00_axis_tvalid && !bus.m00_axis_tready;
        held    = {bus.m00_axis_tlast, bus.m00_axis_tstrb, bus.m00_axis_tdata};
      end
    end
  end

  // Present one byte and hold it until the edge that accepts it.
  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.s00_axis_tvalid = 1'b1;
    bus.s00_axis_tdata  = d;
    bus.s00_axis_tlast  = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      ok = bus.s00_axis_tready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_accept_timeout: byte 0x%0h, tready=%0b, expected 1", d, bus.s00_axis_tready);
    end
  endtask

  task automatic send_seq(input logic [7:0] first, input logic [7:0] step,
                          input int n, input bit last_at_end);
    for (int i = 0; i < n; i++)
      send_byte(8'(first + step * 8'(i)), last_at_end && (i == n - 1));
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tlast  = 1'b0;
  endtask

  task automatic drain_and_check(input int exp_pkts);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    @(negedge clk);
    #3;
    check("pkt_count", 64'(pkt_count), 64'(exp_pkts));
  endtask

  // Stall the consumer for 5 cycles once the first word is presented.
  task automatic stall_output();
    int n;
    n = 0;
    while (!bus.m00_axis_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_word_seen", 64'(bus.m00_axis_tvalid), 64'(1));
    bus.m00_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_s_tready", 64'(bus.s00_axis_tready), 64'(0));
      @(negedge clk);
    end
    bus.m00_axis_tready = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_m_tvalid", 64'(bus.m00_axis_tvalid), 64'(0));
    check("rst_m_tdata", 64'(bus.m00_axis_tdata), 64'(0));
    check("rst_m_tstrb", 64'(bus.m00_axis_tstrb), 64'(0));
    check("rst_m_tlast", 64'(bus.m00_axis_tlast), 64'(0));
    check("rst_s_tready", 64'(bus.s00_axis_tready), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_forced_last", 64'(forced_last), 64'(0));
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tdata  = '0;
    bus.s00_axis_tlast  = 1'b0;
    bus.m00_axis_tready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("s_tready_after_reset", 64'(bus.s00_axis_tready), 64'(1));
    @(negedge clk);

    // Two full words, tlast on the second.
    expect_word(32'h44332211, 4'hF, 1'b0, 1'b0);
    expect_word(32'h88776655, 4'hF, 1'b1, 1'b0);
    send_seq(8'h11, 8'h11, 8, 1'b1);
    drain_and_check(1);

    // Partial trailing word.
    expect_word(32'h04030201, 4'hF, 1'b0, 1'b0);
    expect_word(32'h00000605, 4'h3, 1'b1, 1'b0);
    send_seq(8'h01, 8'h01, 6, 1'b1);
    drain_and_check(2);

    // Single-byte packet, word presented one cycle after acceptance.
    expect_word(32'h000000AB, 4'h1, 1'b1, 1'b0);
    send_seq(8'hAB, 8'h01, 1, 1'b1);
    #1;
    check("single_latency_valid", 64'(bus.m00_axis_tvalid), 64'(1));
    check("single_latency_data", 64'(bus.m00_axis_tdata), 64'(32'h000000AB));
    drain_and_check(3);

    // Backpressure on the first word of a packet.
    expect_word(32'hC3C2C1C0, 4'hF, 1'b0, 1'b0);
    expect_word(32'hC7C6C5C4, 4'hF, 1'b1, 1'b0);
    fork
      send_seq(8'hC0, 8'h01, 8, 1'b1);
      stall_output();
    join
    drain_and_check(4);

    // No input tlast: the 4-word cap forces tlast on the 4th word.
    expect_word(32'h03020100, 4'hF, 1'b0, 1'b0);
    expect_word(32'h07060504, 4'hF, 1'b0, 1'b0);
    expect_word(32'h0B0A0908, 4'hF, 1'b0, 1'b0);
    expect_word(32'h0F0E0D0C, 4'hF, 1'b1, 1'b1);
    expect_word(32'h13121110, 4'hF, 1'b0, 1'b0);
    send_seq(8'h00, 8'h01, 20, 1'b0);
    drain_and_check(5);

    // Reset in the middle of a packet discards the partial word.
    send_seq(8'h55, 8'h11, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_word(32'hA3A2A1A0, 4'hF, 1'b1, 1'b0);
    send_seq(8'hA0, 8'h01, 4, 1'b1);
    drain_and_check(1);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
